// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for alu32: decodes MIPS opcode/funct, registers operands
// onto the ALU, captures result/flags/branch decision, and hands them off via valid/ready.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [3:0]        alu_control_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_v_flag,
    input  logic              alu_n_flag,
    input  logic              alu_z_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_v,
    output logic              out_n,
    output logic              out_z,
    output logic              out_branch_taken,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;
    localparam logic [3:0] CODE_SLT = 4'b0111;
    localparam logic [3:0] CODE_NOR = 4'b1001;
    localparam logic [3:0] CODE_XOR = 4'b1101;
    localparam logic [3:0] CODE_ILL = 4'b1111;

    state_t     state_reg, state_next;
    br_t        br_reg;
    logic [3:0] dec_code;
    br_t        dec_br;
    logic       accept;
    logic       exec_illegal;
    logic       exec_arith;

    always_comb begin
        dec_code = CODE_ILL;
        dec_br   = BR_NONE;
        case (in_opcode)
            6'b000000: begin
                case (in_funct)
                    6'b100100: dec_code = CODE_AND;
                    6'b100101: dec_code = CODE_OR;
                    6'b100000: dec_code = CODE_ADD;
                    6'b100010: dec_code = CODE_SUB;
                    6'b101010: dec_code = CODE_SLT;
                    6'b100111: dec_code = CODE_NOR;
                    6'b100110: dec_code = CODE_XOR;
                    default:   dec_code = CODE_ILL;
                endcase
            end
            6'b001000: dec_code = CODE_ADD;
            6'b001100: dec_code = CODE_AND;
            6'b001101: dec_code = CODE_OR;
            6'b001110: dec_code = CODE_XOR;
            6'b001010: dec_code = CODE_SLT;
            6'b100011,
            6'b101011: dec_code = CODE_ADD;
            6'b000100: begin
                dec_code = CODE_SUB;
                dec_br   = BR_EQ;
            end
            6'b000101: begin
                dec_code = CODE_SUB;
                dec_br   = BR_NE;
            end
            default:   dec_code = CODE_ILL;
        endcase
    end

    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = DONE;
            DONE: begin
                if (accept)         state_next = EXEC;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // During EXEC the registered code tells us what the ALU is computing.
    assign exec_illegal = (alu_control_code == CODE_ILL);
    assign exec_arith   = (alu_control_code == CODE_ADD) || (alu_control_code == CODE_SUB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            br_reg           <= BR_NONE;
            alu_op1          <= '0;
            alu_op2          <= '0;
            alu_control_code <= CODE_ILL;
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_v            <= 1'b0;
            out_n            <= 1'b0;
            out_z            <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
            op_count         <= '0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                alu_op1          <= in_op1;
                alu_op2          <= in_op2;
                alu_control_code <= dec_code;
                br_reg           <= dec_br;
                op_count         <= op_count + CNT_W'(1);
            end else if ((state_reg == DONE) && out_ready) begin
                alu_control_code <= CODE_ILL;
            end

            if (state_reg == EXEC) begin
                out_valid        <= 1'b1;
                out_result       <= exec_illegal ? '0 : alu_result;
                out_z            <= !exec_illegal && alu_z_flag;
                // alu32 leaves stale v/n on logic ops; only ADD/SUB flags are meaningful.
                out_v            <= exec_arith && alu_v_flag;
                out_n            <= exec_arith && alu_n_flag;
                out_branch_taken <= ((br_reg == BR_EQ) && alu_z_flag) ||
                                    ((br_reg == BR_NE) && !alu_z_flag);
                out_illegal      <= exec_illegal;
            end else if ((state_reg == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural alu32 stand-in plus an instruction-level
// reference model; directed scenarios followed by randomized transactions.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_op1, in_op2;
    logic [DATA_W-1:0] alu_op1, alu_op2;
    logic [3:0]        alu_control_code;
    logic [DATA_W-1:0] alu_result;
    logic              alu_v_flag, alu_n_flag, alu_z_flag;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_v, out_n, out_z, out_branch_taken, out_illegal;
    logic [CNT_W-1:0]  op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    bit pending = 0;

    logic [31:0] junk_res = 32'h0;
    logic        junk_v = 1'b0, junk_n = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct),
        .in_op1(in_op1), .in_op2(in_op2),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control_code(alu_control_code),
        .alu_result(alu_result), .alu_v_flag(alu_v_flag),
        .alu_n_flag(alu_n_flag), .alu_z_flag(alu_z_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_v(out_v), .out_n(out_n), .out_z(out_z),
        .out_branch_taken(out_branch_taken), .out_illegal(out_illegal),
        .op_count(op_count)
    );

    // alu32 stand-in; unused-op flags and undefined-code results are random junk.
    always @(negedge clk) begin
        junk_res = $urandom;
        junk_v   = 1'($urandom_range(0, 1));
        junk_n   = 1'($urandom_range(0, 1));
    end

    always_comb begin
        alu_result = junk_res;
        alu_v_flag = junk_v;
        alu_n_flag = junk_n;
        case (alu_control_code)
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 | alu_op2;
            4'b0010: begin
                alu_result = alu_op1 + alu_op2;
                alu_v_flag = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
                alu_n_flag = alu_result[31];
            end
            4'b0110: begin
                alu_result = alu_op1 - alu_op2;
                alu_v_flag = (alu_op1[31] != alu_op2[31]) && (alu_result[31] != alu_op1[31]);
                alu_n_flag = alu_result[31];
            end
            4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            4'b1001: alu_result = ~(alu_op1 | alu_op2);
            4'b1101: alu_result = alu_op1 ^ alu_op2;
            default: alu_result = junk_res;
        endcase
        alu_z_flag = (alu_result == 32'd0);
    end

    typedef enum {K_AND, K_OR, K_ADD, K_SUB, K_SLT, K_NOR, K_XOR, K_BEQ, K_BNE, K_ILL} kind_t;

    typedef struct {
        logic [31:0] res;
        logic        v, n, z, br, ill;
        logic [3:0]  code;
    } exp_t;

    function automatic kind_t decode(input logic [5:0] opc, input logic [5:0] fun);
        kind_t k;
        k = K_ILL;
        case (opc)
            6'h00: begin
                case (fun)
                    6'h24: k = K_AND;
                    6'h25: k = K_OR;
                    6'h20: k = K_ADD;
                    6'h22: k = K_SUB;
                    6'h2a: k = K_SLT;
                    6'h27: k = K_NOR;
                    6'h26: k = K_XOR;
                    default: k = K_ILL;
                endcase
            end
            6'h08, 6'h23, 6'h2b: k = K_ADD;
            6'h0c: k = K_AND;
            6'h0d: k = K_OR;
            6'h0e: k = K_XOR;
            6'h0a: k = K_SLT;
            6'h04: k = K_BEQ;
            6'h05: k = K_BNE;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic exp_t ref_model(input logic [5:0] opc, input logic [5:0] fun,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        kind_t  k;
        longint s;
        k = decode(opc, fun);
        e.res = 32'd0; e.v = 1'b0; e.n = 1'b0; e.br = 1'b0; e.ill = 1'b0;
        e.code = 4'hF;
        s = 0;
        case (k)
            K_AND: begin e.res = a & b;    e.code = 4'h0; end
            K_OR:  begin e.res = a | b;    e.code = 4'h1; end
            K_NOR: begin e.res = ~(a | b); e.code = 4'h9; end
            K_XOR: begin e.res = a ^ b;    e.code = 4'hD; end
            K_SLT: begin
                e.res  = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
                e.code = 4'h7;
            end
            K_ADD: begin
                s      = longint'($signed(a)) + longint'($signed(b));
                e.code = 4'h2;
            end
            K_SUB, K_BEQ, K_BNE: begin
                s      = longint'($signed(a)) - longint'($signed(b));
                e.code = 4'h6;
            end
            default: e.ill = 1'b1;
        endcase
        if (k == K_ADD || k == K_SUB || k == K_BEQ || k == K_BNE) begin
            e.res = s[31:0];
            e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            e.n   = s[31];
        end
        e.z  = !e.ill && (e.res == 32'd0);
        e.br = ((k == K_BEQ) && (a == b)) || ((k == K_BNE) && (a != b));
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [5:0] opc, input logic [5:0] fun,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input int stall);
        exp_t e;
        e = ref_model(opc, fun, a, b);
        if (pending && !b2b) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("drain_valid", 32'(out_valid), 32'd0);
            check_eq("idle_code", 32'(alu_control_code), 32'hF);
            check_eq("idle_ready", 32'(in_ready), 32'd1);
            pending = 0;
        end
        in_valid = 1'b1; in_opcode = opc; in_funct = fun; in_op1 = a; in_op2 = b;
        out_ready = pending;
        #1;
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = 6'($urandom); in_funct = 6'($urandom);
        in_op1 = $urandom; in_op2 = $urandom;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check_eq("exec_code", 32'(alu_control_code), 32'(e.code));
        check_eq("exec_op1", alu_op1, a);
        check_eq("exec_op2", alu_op2, b);
        check_eq("exec_valid", 32'(out_valid), 32'd0);
        check_eq("op_count", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        check_eq("res_valid", 32'(out_valid), 32'd1);
        check_eq("result", out_result, e.res);
        check_eq("flags_vnz", {29'd0, out_v, out_n, out_z}, {29'd0, e.v, e.n, e.z});
        check_eq("branch", 32'(out_branch_taken), 32'(e.br));
        check_eq("illegal", 32'(out_illegal), 32'(e.ill));
        check_eq("op1_stable", alu_op1, a);
        $display("op opc=%02h fun=%02h a=%08h b=%08h -> res=%08h v%0d n%0d z%0d br%0d ill%0d cnt=%0d",
                 opc, fun, a, b, out_result, out_v, out_n, out_z, out_branch_taken, out_illegal, op_count);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            #1;
            check_eq("stall_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_result", out_result, e.res);
            check_eq("stall_count", 32'(op_count), 32'(exp_cnt));
        end
        pending = 1;
    endtask

    localparam logic [5:0] LEG_OPC [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                            6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h23, 6'h2b,
                                            6'h04, 6'h05};
    localparam logic [5:0] LEG_FUN [7] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h27, 6'h26};

    initial begin
        logic [5:0]  opc, fun;
        logic [31:0] a, b;
        int          idx;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = 6'h00; in_funct = 6'h00; in_op1 = '0; in_op2 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_code", 32'(alu_control_code), 32'hF);
        check_eq("rst_count", 32'(op_count), 32'd0);
        check_eq("rst_op1", alu_op1, 32'd0);
        check_eq("rst_result", out_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset while an ADD is executing: it must vanish without a trace.
        in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h20; in_op1 = 32'd3; in_op2 = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("mid_code", 32'(alu_control_code), 32'h2);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_count", 32'(op_count), 32'd0);
        check_eq("mid_rst_code", 32'(alu_control_code), 32'hF);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_no_output", 32'(out_valid), 32'd0);
        end
        $display("reset mid-EXEC done");

        run_op(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 0, 0);
        run_op(6'h04, 6'h00, 32'h5, 32'h5, 0, 0);
        run_op(6'h05, 6'h00, 32'h5, 32'h5, 1, 0);
        run_op(6'h05, 6'h00, 32'h5, 32'h6, 0, 1);
        run_op(6'h00, 6'h22, 32'h1, 32'h2, 0, 0);
        run_op(6'h00, 6'h26, 32'hF0F0F0F0, 32'hF0F0F0F0, 1, 0);
        run_op(6'h00, 6'h2a, 32'h5, 32'h7, 0, 3);
        run_op(6'h0d, 6'h3f, 32'h00001200, 32'h00000034, 1, 0);
        run_op(6'h3f, 6'h3f, 32'h12345678, 32'h9ABCDEF0, 0, 1);

        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 18);
            if (idx < 7) begin
                opc = 6'h00; fun = LEG_FUN[idx];
            end else if (idx < 16) begin
                opc = LEG_OPC[idx]; fun = 6'($urandom);
            end else begin
                opc = 6'h3f; fun = 6'h00;
                for (int k = 0; k < 20; k++) begin
                    opc = 6'($urandom_range(0, 1) != 0 ? 0 : $urandom);
                    fun = 6'($urandom);
                    if (decode(opc, fun) == K_ILL) break;
                end
                if (decode(opc, fun) != K_ILL) begin
                    opc = 6'h3f;
                end
            end
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = a; end
                1: begin a = 32'h7FFFFFFF; b = $urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h1; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(opc, fun, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("final_drain", 32'(out_valid), 32'd0);
        check_eq("final_code", 32'(alu_control_code), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue-side controller that drives alu32. It accepts decoded MIPS instruction fields and two operands through a valid/ready handshake, and translates opcode/funct into the 4-bit alu_control_code. It presents stable registered operands to the ALU, then captures result, flags and the branch decision into registers. Results leave through a valid/ready output handshake toward writeback and branch logic.

Parameters:
DATA_W, 32, operand/result width (must match alu32)
CNT_W, 16, width of issued-operation counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  controller can accept a request
in_opcode  in  6  MIPS opcode field
in_funct  in  6  MIPS funct field (used when opcode=000000)
in_op1  in  DATA_W  operand 1
in_op2  in  DATA_W  operand 2 (register or pre-extended immediate)
alu_op1  out  DATA_W  to alu32 op1
alu_op2  out  DATA_W  to alu32 op2
alu_control_code  out  4  to alu32 alu_control_code
alu_result  in  DATA_W  from alu32 result
alu_v_flag  in  1  from alu32
alu_n_flag  in  1  from alu32
alu_z_flag  in  1  from alu32
out_valid  out  1  captured result valid
out_ready  in  1  consumer accepts result
out_result  out  DATA_W  captured result
out_v  out  1  overflow (ADD/SUB only)
out_n  out  1  negative (ADD/SUB only)
out_z  out  1  result zero
out_branch_taken  out  1  beq/bne decision
out_illegal  out  1  opcode/funct not supported
op_count  out  CNT_W  number of accepted requests, wraps

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; all out_* = 0; alu_op1/alu_op2=0; alu_control_code=4'b1111; op_count=0. An in-flight operation is discarded; no output is produced for it.
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational.
- Accept = in_valid && in_ready. On accept: register in_op1/in_op2 onto alu_op1/alu_op2; register the decoded code onto alu_control_code; record branch type; op_count += 1 (mod 2^CNT_W); next state=EXEC.
- Decode, opcode 000000 by funct: 100100 AND->0000; 100101 OR->0001; 100000 ADD->0010; 100010 SUB->0110; 101010 SLT->0111; 100111 NOR->1001; 100110 XOR->1101.
- Decode by opcode: 001000 addi->0010; 001100 andi->0000; 001101 ori->0001; 001110 xori->1101; 001010 slti->0111; 100011 lw and 101011 sw->0010; 000100 beq and 000101 bne->0110.
- Anything else is illegal. Code 1111 is issued.
- EXEC (exactly 1 cycle; ALU inputs are stable from registers): at the clock edge ending EXEC, capture:
  - out_result=alu_result and out_z=alu_z_flag.
  - out_v/out_n = alu flags only when the code is 0010 or 0110; otherwise 0. alu32 holds stale v/n on other ops, and those values must not leak.
  - out_branch_taken = alu_z_flag for beq, ~alu_z_flag for bne, 0 otherwise.
  - On illegal: out_result=0, out_v=out_n=out_z=0, out_branch_taken=0, out_illegal=1. Otherwise out_illegal=0.
  - Set out_valid=1 and go to DONE.
- DONE: all out_* held stable while out_valid && !out_ready.
  - out_ready && !in_valid: out_valid=0, alu_control_code=1111, go to IDLE.
  - out_ready && in_valid: accept the new request in the same cycle and go to EXEC. out_valid drops for that EXEC cycle.
- Latency: 2 cycles from accept to out_valid. Peak throughput is one op per 2 cycles.
- alu_op1/alu_op2 change only on accept.
- op_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset mid-EXEC: accept ADD, assert reset next cycle -> out_valid=0, op_count=0, alu_control_code=1111, in_ready=1; no output ever appears for the ADD.
- R-type ADD overflow: op1=32'h7FFFFFFF, op2=32'h00000001, funct 100000 -> alu_control_code=0010; 2 cycles after accept out_result=32'h80000000, out_v=1, out_n=1, out_z=0.
- beq/bne: beq with op1=op2=32'h00000005 -> out_z=1, out_branch_taken=1; bne with the same operands -> out_branch_taken=0; bne with op2=6 -> out_branch_taken=1, out_result=32'hFFFFFFFF.
- Flag masking: SUB 1-2 (out_n=1), then XOR 32'hF0F0F0F0^32'hF0F0F0F0 -> second out_result=0, out_z=1, out_n=0, out_v=0.
- Backpressure and back-to-back: out_ready=0 for 3 cycles after SLT (5<7 -> result 1) -> output held and in_ready=0 throughout. Then out_ready=1 with a pending ori request -> accepted in the same cycle, next result arrives 2 cycles later, op_count=2.
- Illegal and wrap: opcode 111111 -> alu_control_code=1111, out_illegal=1, out_result=0. With CNT_W=2, 4 accepts -> op_count returns to 0.
